// File: rtl/zrb_uart_tx_arbiter.sv
// zrb_uart_tx_arbiter: round-robin, packet-granular owner selection in front of
// a single zrb_uart_tx. The owner keeps the transmitter until it sends a byte
// flagged last, or until it stalls for IDLE_TIMEOUT cycles (0 = never revoke).
//
// Handshake: requester i holds req_valid[i], req_last[i] and its req_data byte
// stable until the cycle req_ack[i] pulses. A byte is taken only when the
// owner is valid and tx_ready is high; tx_start pulses for that one cycle.
// Non-owners are ignored and never acked.
module zrb_uart_tx_arbiter #(
    parameter int REQ_NUM      = 4,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [REQ_NUM-1:0]         req_valid,
    input  logic [REQ_NUM-1:0]         req_last,
    input  logic [8*REQ_NUM-1:0]       req_data,
    output logic [REQ_NUM-1:0]         req_ack,
    output logic [REQ_NUM-1:0]         grant,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready,
    output logic                       timeout,
    output logic [2:0]                 dbg_state,
    output logic [$clog2(REQ_NUM)-1:0] dbg_ptr
);

    localparam int PW = $clog2(REQ_NUM);
    localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OWN   = 3'd1,
        S_SEND  = 3'd2,
        S_BUSY  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [REQ_NUM-1:0]   grant_q, grant_d;
    logic [REQ_NUM-1:0]   ack_q, ack_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 timeout_q, timeout_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        own_q, own_d;
    logic                 last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 scan_found;
    logic [PW-1:0]        scan_win;
    int                   scan_idx;
    logic                 own_valid;
    logic                 own_last;
    logic [7:0]           own_data;
    logic [PW-1:0]        next_own;
    logic                 stall_expire;

    assign own_valid    = req_valid[own_q];
    assign own_last     = req_last[own_q];
    assign own_data     = req_data[int'(own_q)*8 +: 8];
    assign next_own     = (int'(own_q) == REQ_NUM - 1) ? '0 : own_q + 1'b1;
    assign stall_expire = (IDLE_TIMEOUT != 0) && ((int'(cnt_q) + 1) >= IDLE_TIMEOUT);

    // Round-robin scan: first valid requester at or after ptr, wrapping.
    always_comb begin
        scan_found = 1'b0;
        scan_win   = '0;
        scan_idx   = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= REQ_NUM) scan_idx = scan_idx - REQ_NUM;
            if (!scan_found && req_valid[scan_idx]) begin
                scan_found = 1'b1;
                scan_win   = scan_idx[PW-1:0];
            end
        end
    end

    // Next-state and registered-output logic of the ownership FSM.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        timeout_d  = 1'b0;
        ptr_d      = ptr_q;
        own_d      = own_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (scan_found) begin
                    grant_d           = '0;
                    grant_d[scan_win] = 1'b1;
                    own_d             = scan_win;
                    cnt_d             = '0;
                    state_d           = S_OWN;
                end
            end
            S_OWN: begin
                if (own_valid) begin
                    // A valid cycle always clears the stall count, even if the
                    // transmitter is not ready yet; valid also beats timeout.
                    cnt_d = '0;
                    if (tx_ready) begin
                        tx_start_d   = 1'b1;
                        tx_data_d    = own_data;
                        ack_d[own_q] = 1'b1;
                        last_d       = own_last;
                        state_d      = S_SEND;
                    end
                end else if (stall_expire) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    ptr_d     = next_own;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                // The transmitter samples start && ready at the end of this cycle.
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (!tx_ready) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (tx_ready) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = next_own;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_OWN;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            timeout_q  <= 1'b0;
            ptr_q      <= '0;
            own_q      <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            timeout_q  <= timeout_d;
            ptr_q      <= ptr_d;
            own_q      <= own_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    assign req_ack   = ack_q;
    assign grant     = grant_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;

endmodule
